multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 40 ++++
 rtl/multicycle_controller_decode.sv | 48 ++++
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/ext
// fields and data-memory control words.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [3:0] OPC_RTYPE = 4'b0000;
    localparam logic [3:0] OPC_MEM   = 4'b0100;
    localparam logic [3:0] OPC_CMPI  = 4'b1011;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_CMP   = 4'b1011;

    localparam logic [2:0] MEMC_NONE = 3'b000;
    localparam logic [2:0] MEMC_LOAD = 3'b110;
    localparam logic [2:0] MEMC_STOR = 3'b101;

    // Opcodes that take the immediate as ALU operand B.
    function automatic logic is_imm_opcode(input logic [3:0] opc);
        case (opc)
            4'b0001, 4'b0010, 4'b0011, 4'b0101,
            4'b0110, 4'b1001, 4'b1011, 4'b1110: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Extended R-type ALU codes (1100-1111), optionally disabled.
    function automatic logic is_ext_alu(input logic [3:0] ext);
        return (ext[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/multicycle_controller_decode.sv
// Purely combinational classification of a latched instruction word.
module instr_decode
    import multicycle_controller_pkg::*;
#(
    parameter int ALLOW_EXT_ALU = 1
)
(
    input  logic [3:0] opcode,
    input  logic [3:0] ext,
    output logic [3:0] op,
    output logic       select_immediate,
    output logic [2:0] mem_control,
    output logic       comparison,
    output logic       is_mem,
    output logic       is_illegal
);

    // Classify opcode/ext into ALU, memory or illegal; illegal words drive no fields.
    always_comb begin
        op               = 4'b0000;
        select_immediate = 1'b0;
        mem_control      = MEMC_NONE;
        comparison       = 1'b0;
        is_mem           = 1'b0;
        is_illegal       = 1'b0;
        if (opcode == OPC_RTYPE) begin
            if ((ALLOW_EXT_ALU == 0) && is_ext_alu(ext)) begin
                is_illegal = 1'b1;
            end else begin
                op         = ext;
                comparison = (ext == EXT_CMP);
            end
        end else if (is_imm_opcode(opcode)) begin
            op               = opcode;
            select_immediate = 1'b1;
            comparison       = (opcode == OPC_CMPI);
        end else if (opcode == OPC_MEM && ext == EXT_LOAD) begin
            mem_control = MEMC_LOAD;
            is_mem      = 1'b1;
        end else if (opcode == OPC_MEM && ext == EXT_STOR) begin
            mem_control = MEMC_STOR;
            is_mem      = 1'b1;
        end else begin
            is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch/decode/execute with a bounded data-memory
// wait and a sticky trap state for illegal words and memory timeouts.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int INSTR_W       = 16,
    parameter int MEM_TIMEOUT   = 15,
    parameter int ALLOW_EXT_ALU = 1
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    input  logic               mem_ready,
    output logic               ir_load,
    output logic               pc_en,
    output logic [3:0]         op,
    output logic               select_immediate,
    output logic [2:0]         mem_control,
    output logic               comparison,
    output logic               write_reg,
    output logic               illegal
);

    // Wait count of the last MEM cycle before a timeout trap.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [INSTR_W-1:0] ir_reg;
    logic [7:0]         wait_cnt_reg;

    logic [3:0] dec_op;
    logic       dec_sel;
    logic [2:0] dec_memc;
    logic       dec_cmp;
    logic       dec_is_mem;
    logic       dec_is_illegal;
    logic       mem_timeout;

    // Only the opcode and ext fields steer control; other bits are operand data.
    logic unused_ir;
    assign unused_ir = ^ir_reg;

    instr_decode #(
        .ALLOW_EXT_ALU (ALLOW_EXT_ALU)
    ) u_decode (
        .opcode           (ir_reg[15:12]),
        .ext              (ir_reg[7:4]),
        .op               (dec_op),
        .select_immediate (dec_sel),
        .mem_control      (dec_memc),
        .comparison       (dec_cmp),
        .is_mem           (dec_is_mem),
        .is_illegal       (dec_is_illegal)
    );

    assign mem_timeout = (wait_cnt_reg == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction register captures the word on the accepted fetch cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg <= '0;
        end else if (state_reg == FETCH && instr_valid) begin
            ir_reg <= instruction;
        end
    end

    // Memory wait counter: zero on every MEM entry, counts cycles spent in MEM.
    always_ff @(posedge clk) begin
        if (reset || state_reg != MEM) begin
            wait_cnt_reg <= 8'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
        end
    end

    // Next-state and output decode; memory completion wins over timeout.
    always_comb begin
        state_next       = state_reg;
        ir_load          = 1'b0;
        pc_en            = 1'b0;
        op               = 4'b0000;
        select_immediate = 1'b0;
        mem_control      = MEMC_NONE;
        comparison       = 1'b0;
        write_reg        = 1'b0;
        illegal          = 1'b0;
        case (state_reg)
            FETCH: begin
                if (instr_valid) begin
                    ir_load    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                op               = dec_op;
                select_immediate = dec_sel;
                comparison       = dec_cmp;
                if (dec_is_illegal) begin
                    state_next = TRAP;
                end else if (dec_is_mem) begin
                    state_next = MEM;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                op               = dec_op;
                select_immediate = dec_sel;
                comparison       = dec_cmp;
                pc_en            = 1'b1;
                write_reg        = !dec_cmp;
                state_next       = FETCH;
            end
            MEM: begin
                op               = dec_op;
                select_immediate = dec_sel;
                comparison       = dec_cmp;
                mem_control      = dec_memc;
                if (mem_ready) begin
                    if (dec_memc == MEMC_LOAD) begin
                        state_next = WB;
                    end else begin
                        pc_en      = 1'b1;
                        state_next = FETCH;
                    end
                end else if (mem_timeout) begin
                    state_next = TRAP;
                end
            end
            WB: begin
                op               = dec_op;
                select_immediate = dec_sel;
                comparison       = dec_cmp;
                write_reg        = 1'b1;
                pc_en            = 1'b1;
                state_next       = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_next = TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (extended ALU on/off,
// different memory timeouts) driven with identical stimulus.
module tb_multicycle_controller;

    localparam int TMO0 = 15;
    localparam int TMO1 = 3;

    localparam logic [1:0] K_ALU  = 2'd0;
    localparam logic [1:0] K_LOAD = 2'd1;
    localparam logic [1:0] K_STOR = 2'd2;
    localparam logic [1:0] K_ILL  = 2'd3;

    typedef struct packed {
        logic [3:0] op;
        logic       sel;
        logic       cmp;
        logic [1:0] kind;
    } dec_t;

    typedef struct {
        logic [15:0] instr;
        int          dly;
        logic [3:0]  op;
        logic        sel;
        logic        cmp;
        logic [1:0]  kind0;
        logic [1:0]  kind1;
        string       nm;
    } vec_t;

    typedef struct {
        logic [12:0] e0;
        logic [12:0] e1;
        string       nm;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        mem_ready;

    logic       ir_load0, pc_en0, sel0, cmp0, wr0, ill0;
    logic [3:0] op0;
    logic [2:0] memc0;
    logic       ir_load1, pc_en1, sel1, cmp1, wr1, ill1;
    logic [3:0] op1;
    logic [2:0] memc1;

    int total = 0;
    int bad   = 0;
    sb_t  sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    multicycle_controller #(.INSTR_W(16), .MEM_TIMEOUT(TMO0), .ALLOW_EXT_ALU(1)) dut0 (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .ir_load(ir_load0), .pc_en(pc_en0), .op(op0),
        .select_immediate(sel0), .mem_control(memc0), .comparison(cmp0),
        .write_reg(wr0), .illegal(ill0)
    );

    multicycle_controller #(.INSTR_W(16), .MEM_TIMEOUT(TMO1), .ALLOW_EXT_ALU(0)) dut1 (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .ir_load(ir_load1), .pc_en(pc_en1), .op(op1),
        .select_immediate(sel1), .mem_control(memc1), .comparison(cmp1),
        .write_reg(wr1), .illegal(ill1)
    );

    function automatic logic [12:0] ov(input logic ir, input logic pc, input logic [3:0] o,
                                       input logic s, input logic [2:0] m, input logic c,
                                       input logic w, input logic il);
        return {ir, pc, o, s, m, c, w, il};
    endfunction

    // Reference decode written from the instruction-set description.
    function automatic dec_t ref_dec(input logic [3:0] opc, input logic [3:0] ext, input bit allow);
        dec_t d;
        d.op = 4'd0; d.sel = 1'b0; d.cmp = 1'b0; d.kind = K_ILL;
        if (opc == 4'd0) begin
            if (allow || ext < 4'd12) begin
                d.op = ext; d.cmp = (ext == 4'd11); d.kind = K_ALU;
            end
        end else if (opc inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9, 4'd11, 4'd14}) begin
            d.op = opc; d.sel = 1'b1; d.cmp = (opc == 4'd11); d.kind = K_ALU;
        end else if (opc == 4'd4 && ext == 4'd0) begin
            d.kind = K_LOAD;
        end else if (opc == 4'd4 && ext == 4'd4) begin
            d.kind = K_STOR;
        end
        return d;
    endfunction

    // Expected outputs k cycles after the fetch cycle; mem_ready pulses at k == 2+dly.
    function automatic logic [12:0] exp_cycle(input dec_t d, input int k, input int dly, input int tmo);
        logic [2:0] m;
        if (k == 0) return ov(1, 0, 0, 0, 0, 0, 0, 0);
        if (k == 1) return ov(0, 0, d.op, d.sel, 0, d.cmp, 0, 0);
        case (d.kind)
            K_ALU: begin
                if (k == 2) return ov(0, 1, d.op, d.sel, 0, d.cmp, !d.cmp, 0);
                return 13'd0;
            end
            K_ILL: return ov(0, 0, 0, 0, 0, 0, 0, 1);
            default: begin
                m = (d.kind == K_LOAD) ? 3'b110 : 3'b101;
                if (dly >= tmo) begin
                    if (k < 2 + tmo) return ov(0, 0, 0, 0, m, 0, 0, 0);
                    return ov(0, 0, 0, 0, 0, 0, 0, 1);
                end
                if (k < 2 + dly) return ov(0, 0, 0, 0, m, 0, 0, 0);
                if (k == 2 + dly) return ov(0, d.kind == K_STOR, 0, 0, m, 0, 0, 0);
                if (d.kind == K_LOAD && k == 3 + dly) return ov(0, 1, 0, 0, 0, 0, 1, 0);
                return 13'd0;
            end
        endcase
    endfunction

    // Pop one scoreboard entry and compare both instances against it.
    task automatic check_pop();
        sb_t e;
        logic [12:0] a0, a1;
        e  = sb_q.pop_front();
        a0 = {ir_load0, pc_en0, op0, sel0, memc0, cmp0, wr0, ill0};
        a1 = {ir_load1, pc_en1, op1, sel1, memc1, cmp1, wr1, ill1};
        total++;
        if (a0 !== e.e0) begin
            bad++;
            $display("FAIL %s dut0 got=%013b want=%013b", e.nm, a0, e.e0);
        end
        total++;
        if (a1 !== e.e1) begin
            bad++;
            $display("FAIL %s dut1 got=%013b want=%013b", e.nm, a1, e.e1);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, compare on falling edge.
    task automatic cyc(input logic iv, input logic mr, input logic [12:0] e0,
                       input logic [12:0] e1, input string nm);
        sb_t e;
        instr_valid = iv;
        mem_ready   = mr;
        e.e0 = e0; e.e1 = e1; e.nm = nm;
        sb_q.push_back(e);
        @(negedge clk);
        check_pop();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset       = 1'b1;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 13'd0, 13'd0, nm);
    endtask

    // Issue one instruction; the bus is inverted after fetch and instr_valid is
    // also raised in DECODE to show both are ignored there.
    task automatic run(input logic [15:0] ins, input int dly, input dec_t d0, input dec_t d1,
                       input string nm);
        int n;
        n = 5 + ((dly < TMO0) ? dly : TMO0);
        for (int k = 0; k < n; k++) begin
            instruction = (k == 0) ? ins : ~ins;
            cyc(k <= 1, k == 2 + dly, exp_cycle(d0, k, dly, TMO0), exp_cycle(d1, k, dly, TMO1), nm);
        end
        do_reset({nm, "_rst"});
    endtask

    function automatic vec_t mk(input logic [15:0] i, input int dly, input logic [3:0] o,
                                input logic s, input logic c, input logic [1:0] k0,
                                input logic [1:0] k1, input string nm);
        vec_t v;
        v.instr = i; v.dly = dly; v.op = o; v.sel = s; v.cmp = c;
        v.kind0 = k0; v.kind1 = k1; v.nm = nm;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_t d0, d1;
        logic [7:0]  p;
        logic [15:0] w;

        tbl.push_back(mk(16'h0152,  0, 4'h5, 0, 0, K_ALU,  K_ALU,  "add"));
        tbl.push_back(mk(16'h00B0,  0, 4'hB, 0, 1, K_ALU,  K_ALU,  "cmp_r"));
        tbl.push_back(mk(16'hB105,  0, 4'hB, 1, 1, K_ALU,  K_ALU,  "cmpi"));
        tbl.push_back(mk(16'h5123,  0, 4'h5, 1, 0, K_ALU,  K_ALU,  "imm5"));
        tbl.push_back(mk(16'h00C0,  0, 4'hC, 0, 0, K_ALU,  K_ILL,  "ext_c"));
        tbl.push_back(mk(16'h00F0,  0, 4'hF, 0, 0, K_ALU,  K_ILL,  "ext_f"));
        tbl.push_back(mk(16'h4203,  4, 4'h0, 0, 0, K_LOAD, K_LOAD, "load_d4"));
        tbl.push_back(mk(16'h4243,  1, 4'h0, 0, 0, K_STOR, K_STOR, "stor_d1"));
        tbl.push_back(mk(16'h4243,  2, 4'h0, 0, 0, K_STOR, K_STOR, "stor_d2"));
        tbl.push_back(mk(16'h4203,  3, 4'h0, 0, 0, K_LOAD, K_LOAD, "load_d3"));
        tbl.push_back(mk(16'h4203, 14, 4'h0, 0, 0, K_LOAD, K_LOAD, "load_d14"));
        tbl.push_back(mk(16'h4203, 15, 4'h0, 0, 0, K_LOAD, K_LOAD, "load_d15"));
        tbl.push_back(mk(16'h4203, 99, 4'h0, 0, 0, K_LOAD, K_LOAD, "load_hang"));
        tbl.push_back(mk(16'h7000,  0, 4'h0, 0, 0, K_ILL,  K_ILL,  "opc7"));
        tbl.push_back(mk(16'h4010,  0, 4'h0, 0, 0, K_ILL,  K_ILL,  "mem_bad_ext"));
        tbl.push_back(mk(16'hF000,  0, 4'h0, 0, 0, K_ILL,  K_ILL,  "opcf"));

        instruction = 16'h0000;
        reset       = 1'b1;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset_state");

        foreach (tbl[i]) begin
            d0.op = tbl[i].op; d0.sel = tbl[i].sel; d0.cmp = tbl[i].cmp; d0.kind = tbl[i].kind0;
            d1 = d0;
            d1.kind = tbl[i].kind1;
            if (tbl[i].kind1 == K_ILL) begin
                d1.op = 4'd0; d1.sel = 1'b0; d1.cmp = 1'b0;
            end
            run(tbl[i].instr, tbl[i].dly, d0, d1, tbl[i].nm);
        end

        // Reset in the middle of a load with mem_ready high: no completion pulses.
        d0 = ref_dec(4'h4, 4'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            instruction = (k == 0) ? 16'h4203 : 16'h0000;
            cyc(k == 0, 1'b0, exp_cycle(d0, k, 99, TMO0), exp_cycle(d0, k, 99, TMO1), "mid_mem");
        end
        reset     = 1'b1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 13'd0, 13'd0, "mid_mem_rst");
        end

        // Full opcode/ext sweep with random filler in the operand fields.
        for (int i = 0; i < 256; i++) begin
            p = 8'(i);
            w = {p[7:4], 4'($urandom), p[3:0], 4'($urandom)};
            run(w, 0, ref_dec(p[7:4], p[3:0], 1'b1), ref_dec(p[7:4], p[3:0], 1'b0), "sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
